// File: rtl/i2c_sram_pkg.sv
// rtl/i2c_sram_pkg.sv - shared types and helpers for the oversampled I2C slave SRAM
package i2c_sram_pkg;

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, MEM_ADDR, MEM_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/i2c_sram_burst_line_sync.sv
// rtl/i2c_sram_burst_line_sync.sv - SCL/SDA synchronisers, edge detect and START/STOP pulses
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_q;
  logic [SYNC_STAGES-1:0] sda_q;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Reset to the idle-bus level so leaving reset never fabricates an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
      scl_d <= scl_q[SYNC_STAGES-1];
      sda_d <= sda_q[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_q[SYNC_STAGES-1];
  assign sda_s    = sda_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_sram_burst.sv
// rtl/i2c_sram_burst.sv - parametrised I2C slave SRAM with burst read/write and pointer auto-increment
module i2c_sram_burst #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int DATA_BYTES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scl,
  input  logic                    sda_in,
  output logic                    sda_oe,
  input  logic [6:0]              my_addr,
  output logic [6:0]              rcvd_device_address,
  output logic                    rcvd_mode,
  output logic [8*DATA_BYTES-1:0] curr_data,
  output logic [ADDR_W-1:0]       mem_ptr,
  output logic                    busy,
  output logic                    wr_strobe
);
  import i2c_sram_pkg::*;

  localparam int DW         = 8 * DATA_BYTES;
  localparam int ADDR_BYTES = ceil_div(ADDR_W, 8);
  localparam int AWF        = 8 * ADDR_BYTES;
  localparam int AWX        = AWF + 1;
  localparam logic [AWF:0] DEPTH_X = AWX'(DEPTH);

  logic scl_rise, scl_fall, start, stop, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  logic [DW-1:0]     mem [DEPTH];
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        byte_cnt;
  logic              ack_seen;
  logic              rd_load;
  logic [6:0]        sh;
  logic [6:0]        my_addr_q;
  logic [AWF-1:0]    addr_sh;
  logic [DW-1:0]     word_sh;
  logic [DW-1:0]     rd_word;
  logic [ADDR_W-1:0] next_ptr;
  logic              last_addr_byte;
  logic              last_data_byte;
  logic              addr_oob;
  logic              wr_now;

  assign next_ptr       = (mem_ptr == ADDR_W'(DEPTH - 1)) ? '0 : mem_ptr + 1'b1;
  assign last_addr_byte = (byte_cnt == 8'(ADDR_BYTES - 1));
  assign last_data_byte = (byte_cnt == 8'(DATA_BYTES - 1));
  assign addr_oob       = ({1'b0, addr_sh} >= DEPTH_X);
  assign wr_now         = !reset && !start && !stop && (state == WR_ACK) && scl_rise && last_data_byte;

  always_ff @(posedge clk) begin
    if (wr_now) mem[mem_ptr] <= word_sh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      sda_oe              <= 1'b0;
      busy                <= 1'b0;
      rcvd_device_address <= '0;
      rcvd_mode           <= 1'b0;
      curr_data           <= '0;
      mem_ptr             <= '0;
      wr_strobe           <= 1'b0;
      bit_cnt             <= '0;
      byte_cnt            <= '0;
      ack_seen            <= 1'b0;
      rd_load             <= 1'b0;
      sh                  <= '0;
      my_addr_q           <= '0;
      addr_sh             <= '0;
      word_sh             <= '0;
      rd_word             <= '0;
    end else begin
      wr_strobe <= 1'b0;
      rd_load   <= 1'b0;
      // Read data lands one clk after the pointer it depends on.
      if (rd_load) curr_data <= mem[mem_ptr];
      if (start) begin
        state     <= DEV_ADDR;
        bit_cnt   <= '0;
        byte_cnt  <= '0;
        ack_seen  <= 1'b0;
        busy      <= 1'b0;
        sda_oe    <= 1'b0;
        my_addr_q <= my_addr;
      end else if (stop) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        bit_cnt  <= '0;
        ack_seen <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          DEV_ADDR: if (scl_rise) begin
            sh      <= {sh[5:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rcvd_device_address <= sh;
              rcvd_mode           <= sda_s;
              bit_cnt             <= '0;
              state               <= (sh == my_addr_q) ? DEV_ACK : IGNORE;
            end
          end
          DEV_ACK: if (scl_fall) begin
            if (!ack_seen) sda_oe <= ~ACK;
            else begin
              sda_oe   <= 1'b0;
              ack_seen <= 1'b0;
              busy     <= 1'b1;
              byte_cnt <= '0;
              state    <= MEM_ADDR;
            end
          end else if (scl_rise) ack_seen <= 1'b1;
          MEM_ADDR: if (scl_rise) begin
            addr_sh <= {addr_sh[AWF-2:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= MEM_ACK;
            end
          end
          MEM_ACK: if (scl_fall) begin
            if (!ack_seen) begin
              if (last_addr_byte && addr_oob) begin
                sda_oe <= ~NACK;
                state  <= IGNORE;
              end else begin
                sda_oe <= ~ACK;
                if (last_addr_byte) begin
                  mem_ptr <= addr_sh[ADDR_W-1:0];
                  rd_load <= rcvd_mode;
                end
              end
            end else begin
              ack_seen <= 1'b0;
              byte_cnt <= last_addr_byte ? 8'd0 : byte_cnt + 8'd1;
              if (!last_addr_byte) begin
                sda_oe <= 1'b0;
                state  <= MEM_ADDR;
              end else if (rcvd_mode) begin
                sda_oe  <= ~curr_data[DW-1];
                rd_word <= curr_data << 1;
                state   <= RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= WR_DATA;
              end
            end
          end else if (scl_rise) ack_seen <= 1'b1;
          WR_DATA: if (scl_rise) begin
            word_sh <= {word_sh[DW-2:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= WR_ACK;
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!ack_seen) sda_oe <= ~ACK;
            else begin
              sda_oe   <= 1'b0;
              ack_seen <= 1'b0;
              byte_cnt <= last_data_byte ? 8'd0 : byte_cnt + 8'd1;
              state    <= WR_DATA;
            end
          end else if (scl_rise) begin
            ack_seen <= 1'b1;
            if (last_data_byte) begin
              curr_data <= word_sh;
              wr_strobe <= 1'b1;
              mem_ptr   <= next_ptr;
            end
          end
          RD_DATA: if (scl_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= RD_ACK;
            end
          end else if (scl_fall) begin
            sda_oe  <= ~rd_word[DW-1];
            rd_word <= rd_word << 1;
          end
          RD_ACK: if (scl_fall) begin
            if (!ack_seen) sda_oe <= 1'b0;
            else begin
              ack_seen <= 1'b0;
              state    <= RD_DATA;
              // byte_cnt wrapped to 0 means a fresh word was reloaded into curr_data.
              if (byte_cnt == 8'd0) begin
                sda_oe  <= ~curr_data[DW-1];
                rd_word <= curr_data << 1;
              end else begin
                sda_oe  <= ~rd_word[DW-1];
                rd_word <= rd_word << 1;
              end
            end
          end else if (scl_rise) begin
            if (sda_s == NACK) begin
              state <= IGNORE;
              if (last_data_byte) mem_ptr <= next_ptr;
            end else begin
              ack_seen <= 1'b1;
              byte_cnt <= last_data_byte ? 8'd0 : byte_cnt + 8'd1;
              if (last_data_byte) begin
                mem_ptr <= next_ptr;
                rd_load <= 1'b1;
              end
            end
          end
          IGNORE: sda_oe <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_sram_burst.sv
// tb/tb_i2c_sram_burst.sv - bus-master bench with a read-data scoreboard for i2c_sram_burst
module tb_i2c_sram_burst;
  import i2c_sram_pkg::*;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe, sda_oe2;
  logic [6:0]  rcvd_dev, rcvd_dev2;
  logic        rcvd_mode, rcvd_mode2;
  logic [15:0] curr_data, curr_data2;
  logic [7:0]  mem_ptr, mem_ptr2;
  logic        busy, busy2;
  logic        wr_strobe, wr_strobe2;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          wr_cnt2 = 0;
  logic        oe_seen = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [15:0] wbuf[$];

  assign sda_line = sda_m & ~sda_oe & ~sda_oe2;

  always #5 clk = ~clk;

  i2c_sram_burst dut (
    .clk(clk), .reset(reset), .scl(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .my_addr(7'h3C), .rcvd_device_address(rcvd_dev), .rcvd_mode(rcvd_mode),
    .curr_data(curr_data), .mem_ptr(mem_ptr), .busy(busy), .wr_strobe(wr_strobe)
  );

  i2c_sram_burst #(.ADDR_W(8), .DEPTH(200)) dut2 (
    .clk(clk), .reset(reset), .scl(scl_m), .sda_in(sda_line), .sda_oe(sda_oe2),
    .my_addr(7'h2A), .rcvd_device_address(rcvd_dev2), .rcvd_mode(rcvd_mode2),
    .curr_data(curr_data2), .mem_ptr(mem_ptr2), .busy(busy2), .wr_strobe(wr_strobe2)
  );

  always @(negedge clk) begin
    if (wr_strobe)  wr_cnt++;
    if (wr_strobe2) wr_cnt2++;
    if (sda_oe)     oe_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic smp);
    sda_m = b; tick(HALF);
    scl_m = 1'b1; tick(HALF / 2);
    smp = sda_line; tick(HALF / 2);
    scl_m = 1'b0; tick(2);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(HALF);
    scl_m = 1'b1; tick(HALF);
    sda_m = 1'b0; tick(HALF);
    scl_m = 1'b0; tick(2);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(HALF);
    scl_m = 1'b1; tick(HALF);
    sda_m = 1'b1; tick(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, d);
      b[i] = d;
    end
    clk_bit(nack, d);
  endtask

  task automatic wr_txn(input logic [6:0] dev, input logic [7:0] ma, output logic ok);
    logic a;
    ok = 1'b1;
    bus_start();
    send_byte({dev, 1'b0}, a); ok &= ~a;
    send_byte(ma, a);          ok &= ~a;
    foreach (wbuf[i]) begin
      send_byte(wbuf[i][15:8], a); ok &= ~a;
      send_byte(wbuf[i][7:0], a);  ok &= ~a;
    end
    bus_stop();
  endtask

  task automatic rd_txn(input logic [6:0] dev, input logic [7:0] ma, input int nwords, output logic ok);
    logic a;
    logic [7:0] b;
    ok = 1'b1;
    bus_start();
    send_byte({dev, 1'b1}, a); ok &= ~a;
    send_byte(ma, a);          ok &= ~a;
    for (int i = 0; i < 2 * nwords; i++) begin
      recv_byte(i == 2 * nwords - 1, b);
      got_q.push_back(b);
    end
    bus_stop();
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(4);
    checks++;
    if ({sda_oe, busy, wr_strobe, rcvd_mode} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {sda_oe, busy, wr_strobe, rcvd_mode});
    end
    checks++;
    if ({rcvd_dev, curr_data, mem_ptr} !== 31'd0) begin
      errors++; $display("FAIL reset_values got %h exp 0", {rcvd_dev, curr_data, mem_ptr});
    end
    checks++;
    if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.state, IDLE); end
    reset = 1'b0; tick(4);
  endtask

  task automatic test_write_read();
    logic ok;
    logic [7:0] e, g;
    int w0 = wr_cnt;
    wbuf = '{16'h5093};
    wr_txn(7'h3C, 8'h7C, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_acks got %b exp 1", ok); end
    checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL wr_strobe_count got %0d exp 1", wr_cnt - w0); end
    checks++; if (curr_data !== 16'h5093) begin errors++; $display("FAIL wr_curr got %h exp 5093", curr_data); end
    checks++; if (mem_ptr !== 8'h7D) begin errors++; $display("FAIL wr_ptr got %h exp 7d", mem_ptr); end
    exp_q.push_back(8'h50); exp_q.push_back(8'h93);
    rd_txn(7'h3C, 8'h7C, 1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_acks got %b exp 1", ok); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rd_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rd_byte got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    checks++; if (curr_data !== 16'h5093) begin errors++; $display("FAIL rd_curr got %h exp 5093", curr_data); end
    checks++; if ({rcvd_mode, busy} !== 2'b10) begin errors++; $display("FAIL rd_mode_busy got %b exp 10", {rcvd_mode, busy}); end
  endtask

  task automatic test_burst_wrap();
    logic ok;
    logic [7:0] e, g;
    int w0 = wr_cnt;
    wbuf = '{16'h1111, 16'h2222, 16'h3333};
    wr_txn(7'h3C, 8'hFE, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL burst_wr_acks got %b exp 1", ok); end
    checks++; if (wr_cnt - w0 != 3) begin errors++; $display("FAIL burst_strobes got %0d exp 3", wr_cnt - w0); end
    checks++; if (mem_ptr !== 8'h01) begin errors++; $display("FAIL burst_wr_ptr got %h exp 01", mem_ptr); end
    foreach (wbuf[i]) begin exp_q.push_back(wbuf[i][15:8]); exp_q.push_back(wbuf[i][7:0]); end
    rd_txn(7'h3C, 8'hFE, 3, ok);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL burst_rd_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL burst_rd_byte got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    checks++; if (mem_ptr !== 8'h01) begin errors++; $display("FAIL burst_rd_ptr got %h exp 01", mem_ptr); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1, a2, ok;
    logic [7:0] e, g;
    int w0 = wr_cnt;
    oe_seen = 1'b0;
    bus_start();
    send_byte({7'h3D, 1'b0}, a0);
    send_byte(8'h7C, a1);
    send_byte(8'hDE, a2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wa_busy got %b exp 0", busy); end
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL wa_acks got %b exp 111", {a0, a1, a2}); end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL wa_sda_oe got %b exp 0", oe_seen); end
    checks++; if (rcvd_dev !== 7'h3D) begin errors++; $display("FAIL wa_rcvd got %h exp 3d", rcvd_dev); end
    checks++; if (wr_cnt != w0) begin errors++; $display("FAIL wa_strobes got %0d exp 0", wr_cnt - w0); end
    exp_q.push_back(8'h50); exp_q.push_back(8'h93);
    rd_txn(7'h3C, 8'h7C, 1, ok);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL wa_mem_byte got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_depth_nack();
    logic a0, a1, a2, ok;
    logic [7:0] e, g;
    int w0 = wr_cnt2;
    bus_start();
    send_byte({7'h2A, 1'b0}, a0);
    send_byte(8'hC8, a1);
    checks++; if (dut2.state !== IGNORE) begin errors++; $display("FAIL oob_state got %0d exp %0d", dut2.state, IGNORE); end
    send_byte(8'h12, a2);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b011) begin errors++; $display("FAIL oob_acks got %b exp 011", {a0, a1, a2}); end
    checks++; if (wr_cnt2 != w0 || mem_ptr2 !== 8'h00) begin
      errors++; $display("FAIL oob_nowrite strobes %0d ptr %h exp 0 00", wr_cnt2 - w0, mem_ptr2);
    end
    wbuf = '{16'hBEEF};
    wr_txn(7'h2A, 8'hC7, ok);
    checks++; if (ok !== 1'b1 || wr_cnt2 - w0 != 1) begin
      errors++; $display("FAIL top_word_wr ack %b strobes %0d exp 1 1", ok, wr_cnt2 - w0);
    end
    checks++; if (mem_ptr2 !== 8'h00) begin errors++; $display("FAIL depth_wrap got %h exp 00", mem_ptr2); end
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    rd_txn(7'h2A, 8'hC7, 1, ok);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL top_word_rd got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_abort();
    logic a, ok, d;
    logic [7:0] b;
    int w0;
    wbuf = '{16'hA5A5};
    wr_txn(7'h3C, 8'h10, ok);
    w0 = wr_cnt;
    bus_start();
    send_byte({7'h3C, 1'b0}, a);
    send_byte(8'h10, a);
    send_byte(8'h77, a);
    bus_stop();
    checks++; if (wr_cnt != w0) begin errors++; $display("FAIL abort_stop_strobe got %0d exp 0", wr_cnt - w0); end
    bus_start();
    send_byte({7'h3C, 1'b1}, a);
    for (int i = 0; i < 4; i++) clk_bit(1'b0, d);
    bus_start();
    checks++; if (dut.state !== DEV_ADDR || busy !== 1'b0) begin
      errors++; $display("FAIL abort_restart state %0d busy %b exp %0d 0", dut.state, busy, DEV_ADDR);
    end
    exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    send_byte({7'h3C, 1'b1}, a);
    send_byte(8'h10, a);
    recv_byte(1'b0, b); got_q.push_back(b);
    recv_byte(1'b1, b); got_q.push_back(b);
    bus_stop();
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      b = got_q.pop_front(); checks++;
      if (b !== exp_q[0]) begin errors++; $display("FAIL abort_mem got %h exp %h", b, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, ok;
    logic [7:0] e, g;
    bus_start();
    send_byte({7'h3C, 1'b1}, a0);
    send_byte(8'h7C, a1);
    tick(HALF / 2);
    checks++; if (sda_oe !== 1'b1 || dut.state !== RD_DATA) begin
      errors++; $display("FAIL mid_read sda_oe %b state %0d exp 1 %0d", sda_oe, dut.state, RD_DATA);
    end
    reset = 1'b1; tick(1); reset = 1'b0;
    checks++; if ({sda_oe, busy, mem_ptr, curr_data} !== 26'd0 || dut.state !== IDLE) begin
      errors++; $display("FAIL reset_abort got oe %b busy %b ptr %h cd %h state %0d exp zeros IDLE",
                         sda_oe, busy, mem_ptr, curr_data, dut.state);
    end
    tick(HALF);
    bus_stop();
    exp_q.push_back(8'h50); exp_q.push_back(8'h93);
    rd_txn(7'h3C, 8'h7C, 1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL post_reset_acks got %b exp 1", ok); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL post_reset_byte got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_burst_wrap();
    test_wrong_addr();
    test_depth_nack();
    test_abort();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_sram_burst.md
Name: i2c_sram_burst

Overview:
Parametrised next-generation I2C slave SRAM, clocked from the system clock with oversampled SCL/SDA instead of running on SCL edges. Keeps the existing transaction format: device address + R/W bit, then memory address bytes, then data in both modes. Adds configurable word width, depth and address width, plus burst reads and writes with pointer auto-increment. Out-of-range address NACK and defined abort on STOP or START are also new. Sits on the board-level I2C bus beside the existing single-word slave.

Parameters:
ADDR_W, 8, memory address width in bits; ADDR_BYTES = ceil(ADDR_W/8) address bytes on the wire
DEPTH, 256, number of words; must be <= 2**ADDR_W
DATA_BYTES, 2, bytes per word; word width DW = 8*DATA_BYTES
SYNC_STAGES, 2, synchroniser flops on scl_in and sda_in; must be >= 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
scl  in  1  I2C clock from pad
sda_in  in  1  I2C data from pad
sda_oe  out  1  1 = pull SDA low; the pad is open-drain and 0 releases the line
my_addr  in  7  device address; sampled at each START
rcvd_device_address  out  7  last device address received
rcvd_mode  out  1  last R/W bit; 1 = read
curr_data  out  DW  last word written to memory or loaded for read
mem_ptr  out  ADDR_W  current word pointer
busy  out  1  high from an addressed ACK until STOP or START
wr_strobe  out  1  one-clk pulse when a complete word is written

Behaviour:
- Reset values: all outputs are 0, state = IDLE. Memory contents are not reset.
- Line conditioning:
  - SYNC_STAGES flops, then one edge-detect flop; pin-to-event latency is SYNC_STAGES+1 clk.
  - SCL high and low phases must each last >= SYNC_STAGES+2 clk.
- START: synchronised SDA falls while synchronised SCL is high. Accepted from any state, including mid-byte. Goes to DEV_ADDR, clears the bit counter and busy, and discards any partial word.
- STOP: SDA rises while SCL is high. Goes to IDLE from any state, sets sda_oe=0 on the next clk, discards any partial word.
- Bit timing:
  - SDA is sampled on SCL rising-edge detect.
  - sda_oe changes only on SCL falling-edge detect, so it is never changed while SCL is high.
  - Data is MSB first.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits. On bit 8, latch rcvd_device_address and rcvd_mode. If the address equals my_addr, go to DEV_ACK; otherwise go to IGNORE.
  - DEV_ACK: sda_oe=1 for one SCL period, then busy=1 and go to MEM_ADDR.
  - MEM_ADDR: shift ADDR_BYTES bytes, with a MEM_ACK after each byte. After the last byte:
    - if the address is < DEPTH: load mem_ptr, ACK, and go to WR_DATA when rcvd_mode=0 or RD_DATA when rcvd_mode=1;
    - if the address is >= DEPTH: NACK (sda_oe=0) and go to IGNORE.
  - WR_DATA / WR_ACK:
    - Shift 8 bits, then ACK.
    - After byte DATA_BYTES, write the word to mem[mem_ptr] on the ACK-bit SCL rise, set curr_data, pulse wr_strobe, and advance mem_ptr (DEPTH-1 wraps to 0).
    - Unlimited burst length.
  - RD_DATA:
    - At entry to each word, curr_data = mem[mem_ptr]; data is available 1 clk after the pointer settles.
    - Drive byte k MSB-first: sda_oe = ~bit.
    - After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's bit.
    - ACK (0): next byte. After the last byte of a word, mem_ptr++ with wrap, and reload curr_data.
    - NACK (1): go to IGNORE. The pointer advances only if the word completed.
  - IGNORE: sda_oe=0; wait for STOP or START.
- Read-after-write in the same clk is impossible, because a read reload follows a pointer update by >= 1 clk.
- reset asserted mid-transaction: the next clk forces IDLE with all outputs 0, regardless of bus state.

Decomposition:
- Package i2c_sram_pkg:
  - state enum (IDLE, DEV_ADDR, DEV_ACK, MEM_ADDR, MEM_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - ACK=0 / NACK=1 constants;
  - ceil-div function for ADDR_BYTES.
- Sub-module i2c_line_sync: synchronisers, edge detect, and start/stop flags, each a one-clk pulse (scl_rise, scl_fall, start, stop, sda_s).

Test Plan:
- Write then read, defaults: my_addr=0x3C, write 0x3C/W, mem 0x7C, data 0x5093, STOP, then read 0x7C with NACK -> ACKs on all 4 bytes, wr_strobe one pulse, readback 0x50 then 0x93, curr_data=0x5093.
- Burst with wrap: write 3 words 0x1111, 0x2222, 0x3333 starting at 0xFE, then burst-read 3 words from 0xFE -> mem[0xFE]=0x1111, mem[0xFF]=0x2222, mem[0x00]=0x3333; mem_ptr=0x01 after each transaction.
- Wrong address: send 0x3D while my_addr=0x3C -> sda_oe stays 0 throughout, busy=0, memory unchanged, rcvd_device_address=0x3D.
- DEPTH=200, ADDR_W=8: address 0xC8 -> NACK on the memory-address byte, IGNORE, no write.
- Abort: STOP after 1 data byte of a write to 0x10, then repeated START mid-byte on a read -> mem[0x10] unchanged, no wr_strobe, state DEV_ADDR after START.
- reset=1 for 1 clk during RD_DATA while SDA is driven low -> the next clk has sda_oe=0, state IDLE, mem_ptr=0, and the next transaction works normally.
